// File: rtl/pio_read_arbiter_if.sv
// pio_read_arbiter_if: Avalon-MM read-only master bundle (address/read in, waitrequest/readdata/readdatavalid out)
interface pio_read_arbiter_if #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] address;
    logic              read;
    logic              waitrequest;
    logic [DATA_W-1:0] readdata;
    logic              readdatavalid;
    modport master (output address, read, input waitrequest, readdata, readdatavalid);
    modport slave (input address, read, output waitrequest, readdata, readdatavalid);
endinterface

// File: rtl/pio_read_arbiter.sv
// pio_read_arbiter: round-robin sharing of one registered-readdata PIO slave between two Avalon-MM read masters
module pio_read_arbiter #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    pio_read_arbiter_if.slave m0,
    pio_read_arbiter_if.slave m1,
    output logic [ADDR_W-1:0] s_address,
    output logic              s_read,
    input  logic [DATA_W-1:0] s_readdata,
    output logic              busy
);
    localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, CAPTURE = 2'd2, RESP = 2'd3;
    logic [1:0]        state;
    logic              grant;
    logic              last_grant;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] resp_data;
    logic              pick;
    // m1 wins when it is the only requester, or on a tie when m0 was served last
    assign pick = m1.read && (!m0.read || !last_grant);
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            addr_q     <= '0;
            resp_data  <= '0;
        end else begin
            case (state)
                IDLE: if (m0.read || m1.read) begin
                    grant  <= pick;
                    addr_q <= pick ? m1.address : m0.address;
                    state  <= ISSUE;
                end
                ISSUE: begin
                    last_grant <= grant;
                    state      <= CAPTURE;
                end
                CAPTURE: begin
                    resp_data <= s_readdata;
                    state     <= RESP;
                end
                default: state <= IDLE;
            endcase
        end
    end
    assign s_address        = addr_q;
    assign s_read           = state == ISSUE;
    assign busy             = state != IDLE;
    assign m0.waitrequest   = !(state == ISSUE && !grant);
    assign m1.waitrequest   = !(state == ISSUE && grant);
    assign m0.readdatavalid = state == RESP && !grant;
    assign m1.readdatavalid = state == RESP && grant;
    assign m0.readdata      = resp_data;
    assign m1.readdata      = resp_data;
endmodule
